// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder slice.
// Optional feature macro used by this slice: FULL_ADDER_OVF_EN.
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;
    localparam int FA_LATENCY   = 1;

    // True when a requested operand width is one the adder can be built at.
    function automatic bit fa_width_ok(input int w);
        return (w >= 1) && (w <= FA_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_adder_half_adder.sv
// One-bit half adder; two of these plus an OR make one full-adder cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {c_out, sum_out} = a + b + c_in, one cycle late.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf_out.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
`ifdef FULL_ADDER_OVF_EN
    output logic             ovf_out,
`endif
    output logic             out_valid
);

    // Refuse to build at an unsupported width or if the pipeline depth assumption changes.
    generate
        if (!fa_width_ok(WIDTH)) begin : g_bad_width
            $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
        end
        if (FA_LATENCY != 1) begin : g_bad_latency
            $error("full_adder: only a single register stage is implemented");
        end
    endgenerate

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] tcarry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = c_in;

    // Ripple chain: each cell is two half adders whose carries are ORed.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            half_adder u_ha_ab (
                .x (a[i]),
                .y (b[i]),
                .s (prop[i]),
                .c (gen[i])
            );
            half_adder u_ha_ci (
                .x (prop[i]),
                .y (carry[i]),
                .s (sum[i]),
                .c (tcarry[i])
            );
            assign carry[i+1] = gen[i] | tcarry[i];
        end
    endgenerate

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: the carry into the MSB disagrees with the carry out of it.
    logic ovf;
    assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

    // Overflow flag follows the same capture/hold rules as the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_out <= 1'b0;
        end else if (in_valid) begin
            ovf_out <= ovf;
        end
    end
`endif

    // Capture a qualified result; otherwise hold the last one and drop out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out   <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_out <= sum;
                c_out   <= carry[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8 side by side.
// Honours FULL_ADDER_OVF_EN when the design is built with it.
module tb_full_adder;

    logic       clk;
    logic       rst_n;

    logic [0:0] a_w1, b_w1, sum_w1;
    logic       c_in_w1, valid_in_w1, c_w1, valid_w1;
    logic [7:0] a_w8, b_w8, sum_w8;
    logic       c_in_w8, valid_in_w8, c_w8, valid_w8;
`ifdef FULL_ADDER_OVF_EN
    logic       ovf_w1, ovf_w8;
`endif

    int checks   = 0;
    int failures = 0;

    logic [0:0] exp_sum1;
    logic       exp_c1, exp_v1, exp_ovf1;
    logic [7:0] exp_sum8;
    logic       exp_c8, exp_v8, exp_ovf8;

    full_adder #(.WIDTH(1)) dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a_w1),
        .b         (b_w1),
        .c_in      (c_in_w1),
        .in_valid  (valid_in_w1),
        .sum_out   (sum_w1),
        .c_out     (c_w1),
`ifdef FULL_ADDER_OVF_EN
        .ovf_out   (ovf_w1),
`endif
        .out_valid (valid_w1)
    );

    full_adder #(.WIDTH(8)) dut_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a_w8),
        .b         (b_w8),
        .c_in      (c_in_w8),
        .in_valid  (valid_in_w8),
        .sum_out   (sum_w8),
        .c_out     (c_w8),
`ifdef FULL_ADDER_OVF_EN
        .ovf_out   (ovf_w8),
`endif
        .out_valid (valid_w8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, " w1.sum"},   64'(sum_w1),   64'(exp_sum1));
        checkOutput({where, " w1.c"},     64'(c_w1),     64'(exp_c1));
        checkOutput({where, " w1.valid"}, 64'(valid_w1), 64'(exp_v1));
        checkOutput({where, " w8.sum"},   64'(sum_w8),   64'(exp_sum8));
        checkOutput({where, " w8.c"},     64'(c_w8),     64'(exp_c8));
        checkOutput({where, " w8.valid"}, 64'(valid_w8), 64'(exp_v8));
`ifdef FULL_ADDER_OVF_EN
        checkOutput({where, " w1.ovf"},   64'(ovf_w1),   64'(exp_ovf1));
        checkOutput({where, " w8.ovf"},   64'(ovf_w8),   64'(exp_ovf8));
`endif
    endtask

    // Reference model: integer arithmetic on the operand values.
    task automatic modelReset();
        exp_sum1 = '0; exp_c1 = 1'b0; exp_v1 = 1'b0; exp_ovf1 = 1'b0;
        exp_sum8 = '0; exp_c8 = 1'b0; exp_v8 = 1'b0; exp_ovf8 = 1'b0;
    endtask

    // Drive both adders for one cycle, advance the model at the edge, check at the falling edge.
    task automatic applyStimulus(input string where,
                                 input logic [7:0] av8, input logic [7:0] bv8, input logic cv8, input logic vv8,
                                 input logic av1, input logic bv1, input logic cv1, input logic vv1);
        int tot;
        int stot;
        a_w8 = av8; b_w8 = bv8; c_in_w8 = cv8; valid_in_w8 = vv8;
        a_w1 = av1; b_w1 = bv1; c_in_w1 = cv1; valid_in_w1 = vv1;
        @(posedge clk);
        if (vv8) begin
            tot      = int'(av8) + int'(bv8) + int'(cv8);
            stot     = int'($signed(av8)) + int'($signed(bv8)) + int'(cv8);
            exp_sum8 = 8'(tot % 256);
            exp_c8   = (tot > 255);
            exp_ovf8 = (stot > 127) || (stot < -128);
        end
        exp_v8 = vv8;
        if (vv1) begin
            tot      = int'(av1) + int'(bv1) + int'(cv1);
            stot     = (av1 ? -1 : 0) + (bv1 ? -1 : 0) + int'(cv1);
            exp_sum1 = 1'(tot % 2);
            exp_c1   = (tot > 1);
            exp_ovf1 = (stot > 0) || (stot < -1);
        end
        exp_v1 = vv1;
        @(negedge clk);
        checkAll(where);
    endtask

    initial begin
        logic [1:0] table_w1 [8];
        logic [2:0] combo;
        table_w1 = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

        rst_n = 1'b0;
        a_w1 = '0; b_w1 = '0; c_in_w1 = 1'b0; valid_in_w1 = 1'b0;
        a_w8 = '0; b_w8 = '0; c_in_w8 = 1'b0; valid_in_w8 = 1'b0;
        modelReset();
        #2;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive one-bit truth table, also against the literal sum/carry table.
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            applyStimulus("truth", 8'h00, 8'h00, 1'b0, 1'b0, combo[2], combo[1], combo[0], 1'b1);
            checkOutput("truth.table", 64'({sum_w1, c_w1}), 64'(table_w1[i]));
        end

        // Eight-bit carry boundaries.
        applyStimulus("ff+01", 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus("7f+01", 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("7f+01.sum", 64'(sum_w8), 64'h80);
        applyStimulus("80+80", 8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        // Hold: one valid result, then three idle cycles with changing operands.
        applyStimulus("hold.load", 8'h3C, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("hold.idle", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0,
                          1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        checkOutput("hold.sum", 64'(sum_w8), 64'h97);

        // Reset with a result in flight: outputs clear without a clock edge.
        applyStimulus("flight.load", 8'hA5, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        a_w8 = 8'h44; b_w8 = 8'h22; valid_in_w8 = 1'b1;
        a_w1 = 1'b1;  valid_in_w1 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async.reset");
        @(negedge clk);
        checkAll("reset.held");
        rst_n = 1'b1;
        applyStimulus("post.idle", 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("post.valid", 8'h12, 8'h34, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

        // Random traffic with roughly three quarters of cycles qualified.
        for (int i = 0; i < 300; i++) begin
            applyStimulus("random", 8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(3) != 0),
                          1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1, operand/sum bit width; legal range 1..64.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low, synchronous deassert by the integrator.
REQ-004 Port a  input  WIDTH  operand A, unsigned.
REQ-005 Port b  input  WIDTH  operand B, unsigned.
REQ-006 Port c_in  input  1  carry-in, weight 2^0.
REQ-007 Port in_valid  input  1  operands qualified this cycle.
REQ-008 Port sum_out  output  WIDTH  registered sum bits.
REQ-009 Port c_out  output  1  registered carry-out, weight 2^WIDTH.
REQ-010 Port out_valid  output  1  sum_out/c_out hold a fresh result.
REQ-011 Port ovf_out  output  1  registered signed overflow; present only with FULL_ADDER_OVF_EN.

Function
REQ-012 {c_out, sum_out} SHALL equal a + b + c_in, computed at WIDTH+1 bits, no truncation of carry.
REQ-013 Latency SHALL be exactly 1 cycle: operands sampled at edge N with in_valid=1 appear at outputs after edge N.
REQ-014 out_valid SHALL be in_valid delayed by one cycle; no back-pressure, one result per cycle sustained.
REQ-015 When in_valid=0 at an edge, sum_out/c_out/ovf_out SHALL hold previous values; out_valid SHALL go 0.
REQ-016 Adder SHALL be a ripple chain of WIDTH 1-bit full-adder cells; cell i carry-in = cell i-1 carry-out, cell 0 carry-in = c_in.
REQ-017 Each 1-bit cell SHALL be two half adders plus OR: s = a^b^ci, co = (a&b) | (ci&(a^b)).
REQ-018 Wrap-around: all-ones + all-ones + 1 SHALL give sum all-ones, c_out=1.
REQ-019 No X propagation from ovf path into sum_out/c_out when macro absent.

Reset
REQ-020 rst_n=0 SHALL immediately (asynchronously) force sum_out=0, c_out=0, out_valid=0, ovf_out=0.
REQ-021 Reset mid-operation SHALL discard the in-flight result; first valid output follows first in_valid=1 edge after release.
REQ-022 No other state exists; reset values are the only initial values relied upon.

Configuration
REQ-023 Macro FULL_ADDER_OVF_EN defined: port ovf_out exists, = carry into MSB XOR carry out of MSB, registered with same latency/hold rules as sum_out.
REQ-024 Macro absent: ovf_out port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-025 Package full_adder_pkg SHALL hold FA_MAX_WIDTH=64 and FA_LATENCY=1 constants.
REQ-026 Sub-module half_adder (inputs x, y; outputs s = x^y, c = x&y) SHALL be instantiated twice per bit.
REQ-027 WIDTH outside 1..FA_MAX_WIDTH SHALL cause an elaboration-time error.

Verification
REQ-028 WIDTH=1, all 8 (a,b,c_in) combos from 000 to 111, in_valid=1, 10 time units apart -> next cycle sum_out/c_out = 00,10,10,01,10,01,01,11 (sum,carry).
REQ-029 WIDTH=8, a=0xFF, b=0x01, c_in=0 -> sum_out=0x00, c_out=1, out_valid=1 one cycle later.
REQ-030 WIDTH=8, a=0xFF, b=0xFF, c_in=1 -> sum_out=0xFF, c_out=1.
REQ-031 WIDTH=8, in_valid=1 then 0 for 3 cycles with changing a/b -> outputs hold last result, out_valid=1 then 0.
REQ-032 Result in flight, pull rst_n=0 mid-cycle -> outputs 0 immediately without clock edge; out_valid stays 0 until next in_valid.
REQ-033 With FULL_ADDER_OVF_EN, WIDTH=8, a=0x7F, b=0x01, c_in=0 -> sum_out=0x80, c_out=0, ovf_out=1.
